// File: rtl/uart_bright_cmd.sv
// UART command responder: parses A5/CMD/DATA/CHK frames, updates the brightness setpoint, replies 5A/status/value.
// Optional inter-byte timeout is enabled by defining BRIGHT_TIMEOUT_EN.
module uart_bright_cmd #(
  parameter int             BR_W        = 8,
  parameter logic [BR_W-1:0] STEP       = 8'd16,
  parameter logic [BR_W-1:0] BR_INIT    = 8'd128,
  parameter int             TIMEOUT_CYC = 1600
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdsig,
  input  logic [7:0]      rxdata,
  input  logic            tx_busy,
  output logic            wrsig,
  output logic [7:0]      dataout,
  output logic [BR_W-1:0] brightness,
  output logic            frame_err
);

  typedef enum logic [2:0] {
    IDLE, GET_CMD, GET_DATA, GET_CHK, EXEC, SEND_HDR, SEND_STAT, SEND_VAL
  } state_t;

  typedef enum logic [1:0] {
    PH_PULSE, PH_RISE, PH_FALL
  } phase_t;

  if (BR_W != 8) begin : g_bad_width
    $error("uart_bright_cmd: BR_W must be 8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("uart_bright_cmd: TIMEOUT_CYC must be at least 2");
  end

  state_t          state;
  phase_t          phase;
  logic [7:0]      cmd;
  logic [7:0]      data;
  logic            chk_ok;
  logic [7:0]      status;

  logic [BR_W:0]   sum;
  logic [BR_W:0]   diff;
  logic [BR_W-1:0] new_br;
  logic [7:0]      new_status;
  logic            cmd_known;

`ifdef BRIGHT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_cnt;
`endif

  // 9-bit sum/difference: the top bit flags overflow or borrow for saturation.
  always_comb begin
    sum        = {1'b0, brightness} + {1'b0, STEP};
    diff       = {1'b0, brightness} - {1'b0, STEP};
    new_br     = brightness;
    new_status = 8'h00;
    cmd_known  = (cmd >= 8'h01) && (cmd <= 8'h04);
    if (!chk_ok) begin
      new_status = 8'hEE;
    end else begin
      case (cmd)
        8'h01: new_br = data;
        8'h02: new_br = brightness;
        8'h03: begin
          if (sum[BR_W]) begin
            new_br     = '1;
            new_status = 8'h01;
          end else begin
            new_br = sum[BR_W-1:0];
          end
        end
        8'h04: begin
          if (diff[BR_W]) begin
            new_br     = '0;
            new_status = 8'h01;
          end else begin
            new_br = diff[BR_W-1:0];
          end
        end
        default: new_status = 8'hEC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= PH_PULSE;
      brightness <= BR_INIT;
      wrsig      <= 1'b0;
      dataout    <= '0;
      frame_err  <= 1'b0;
      cmd        <= '0;
      data       <= '0;
      chk_ok     <= 1'b0;
      status     <= '0;
`ifdef BRIGHT_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      wrsig     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rdsig && rxdata == 8'hA5) state <= GET_CMD;
        end
        GET_CMD, GET_DATA, GET_CHK: begin
          if (rdsig) begin
            case (state)
              GET_CMD: begin
                cmd   <= rxdata;
                state <= GET_DATA;
              end
              GET_DATA: begin
                data  <= rxdata;
                state <= GET_CHK;
              end
              default: begin
                // Error flag is raised during EXEC so it never overlaps the header strobe.
                chk_ok    <= (rxdata == (cmd ^ data));
                frame_err <= (rxdata != (cmd ^ data)) || !cmd_known;
                state     <= EXEC;
              end
            endcase
          end
`ifdef BRIGHT_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end
`endif
        end
        EXEC: begin
          brightness <= new_br;
          status     <= new_status;
          dataout    <= 8'h5A;
          wrsig      <= 1'b1;
          phase      <= PH_PULSE;
          state      <= SEND_HDR;
        end
        SEND_HDR, SEND_STAT, SEND_VAL: begin
          case (phase)
            PH_PULSE: phase <= PH_RISE;
            PH_RISE: begin
              if (tx_busy) phase <= PH_FALL;
            end
            PH_FALL: begin
              if (!tx_busy) begin
                phase <= PH_PULSE;
                case (state)
                  SEND_HDR: begin
                    dataout <= status;
                    wrsig   <= 1'b1;
                    state   <= SEND_STAT;
                  end
                  SEND_STAT: begin
                    dataout <= brightness;
                    wrsig   <= 1'b1;
                    state   <= SEND_VAL;
                  end
                  default: state <= IDLE;
                endcase
              end
            end
            default: phase <= PH_PULSE;
          endcase
        end
        default: state <= IDLE;
      endcase
`ifdef BRIGHT_TIMEOUT_EN
      if (rdsig || !(state == GET_CMD || state == GET_DATA || state == GET_CHK) ||
          to_cnt == TO_LAST) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_bright_cmd.sv
// Randomized bench for uart_bright_cmd: frame-level reference model, transmitter emulator and per-cycle compare.
module tb_uart_bright_cmd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rdsig = 1'b0;
  logic [7:0] rxdata = 8'h00;
  logic       tx_busy = 1'b0;
  logic       wrsig;
  logic [7:0] dataout;
  logic [7:0] brightness;
  logic       frame_err;

  always #5 clk = ~clk;

  uart_bright_cmd #(
    .BR_W(8), .STEP(8'd16), .BR_INIT(8'd128), .TIMEOUT_CYC(1600)
  ) dut (
    .clk(clk), .rst(rst), .rdsig(rdsig), .rxdata(rxdata), .tx_busy(tx_busy),
    .wrsig(wrsig), .dataout(dataout), .brightness(brightness), .frame_err(frame_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  int         m_br = 128;
  int         m_idx = 0;
  logic [7:0] m_cmd, m_data;
  int         m_ferr = 0;
  int         exec_ph = 0;
  logic       exp_err = 1'b0;
  int         br_hold = 0;
  bit         started = 0;

  // Observation state
  int          n_ferr = 0;
  int          wr_count = 0;
  logic [23:0] last3 = '0;
  bit          arm = 0;
  int          busy_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int nb;
    logic [7:0] st;
    logic err;
    if (exp_q.size() != 0) return;
    case (m_idx)
      0: if (b == 8'hA5) m_idx = 1;
      1: begin m_cmd = b; m_idx = 2; end
      2: begin m_data = b; m_idx = 3; end
      default: begin
        m_idx = 0;
        nb = m_br;
        st = 8'h00;
        err = 1'b0;
        if (b != (m_cmd ^ m_data)) begin
          st = 8'hEE; err = 1'b1;
        end else if (m_cmd == 8'h01) nb = m_data;
        else if (m_cmd == 8'h02) nb = m_br;
        else if (m_cmd == 8'h03) begin
          nb = m_br + 16;
          if (nb > 255) begin nb = 255; st = 8'h01; end
        end else if (m_cmd == 8'h04) begin
          nb = m_br - 16;
          if (nb < 0) begin nb = 0; st = 8'h01; end
        end else begin
          st = 8'hEC; err = 1'b1;
        end
        m_br = nb;
        exp_q.push_back(8'h5A);
        exp_q.push_back(st);
        exp_q.push_back(8'(nb));
        if (err) m_ferr++;
        exp_err = err;
        exec_ph = 2;
        br_hold = 2;
      end
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1 rdsig = 1'b1; rxdata = b;
    @(posedge clk);
    #1 rdsig = 1'b0;
    model_byte(b);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || tx_busy || arm || busy_left != 0) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check("idle_wait_bound", t < 5000, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
    send_byte(8'hA5, 0);
    send_byte(c, 0);
    send_byte(d, 0);
    send_byte(k, 0);
    wait_idle();
  endtask

  // Compare process plus transmitter emulator, all on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        if (wrsig) begin
          wr_count++;
          check("wrsig_after_busy_fall", tx_busy || arm, 0);
          check("no_err_with_wrsig", frame_err, 0);
          check("wrsig_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("tx_byte", dataout, exp_q.pop_front());
          last3 = {last3[15:0], dataout};
        end
        if (frame_err) n_ferr++;
        if (exec_ph == 2) begin
          check("exec_no_wrsig", wrsig, 0);
          check("exec_frame_err", frame_err, exp_err);
        end else if (exec_ph == 1) begin
          check("hdr_latency", wrsig, 1);
        end
        if (exec_ph > 0) exec_ph--;
        if (br_hold > 0) br_hold--;
        else check("brightness", brightness, m_br);
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) tx_busy = 1'b0;
        end else if (arm) begin
          tx_busy = 1'b1;
          busy_left = $urandom_range(3, 20);
          arm = 0;
        end
        if (wrsig) arm = 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int t;
    logic [7:0] c, d, k;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_wrsig", wrsig, 0);
    check("rst_dataout", dataout, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_brightness", brightness, 8'h80);
    started = 1;

    send_frame(8'h01, 8'h40, 8'h41);
    check("set_brightness", brightness, 8'h40);
    check("set_tx", last3, 24'h5A0040);

    send_frame(8'h01, 8'hF8, 8'hF9);
    send_frame(8'h03, 8'h00, 8'h03);
    check("inc_sat_brightness", brightness, 8'hFF);
    check("inc_sat_tx", last3, 24'h5A01FF);
    send_frame(8'h01, 8'h08, 8'h09);
    send_frame(8'h04, 8'h00, 8'h04);
    check("dec_sat_brightness", brightness, 8'h00);
    check("dec_sat_tx", last3, 24'h5A0100);

    send_frame(8'h01, 8'h33, 8'h32);
    send_frame(8'h01, 8'h40, 8'h00);
    check("badchk_tx", last3, 24'h5AEE33);
    check("badchk_brightness", brightness, 8'h33);
    send_frame(8'h07, 8'h00, 8'h07);
    check("badcmd_tx", last3, 24'h5AEC33);
    check("frame_err_count_a", n_ferr, m_ferr);

    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    send_frame(8'h02, 8'h00, 8'h02);
    check("noise_read_tx", last3, 24'h5A0033);

    // Extra bytes while the response is in flight
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h55, 0);
    t = wr_count;
    send_byte(8'h54, 0);
    while (wr_count == t && exp_q.size() == 3) @(posedge clk);
    #1;
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    wait_idle();
    check("drop_tx", last3, 24'h5A0055);
    send_frame(8'h02, 8'h00, 8'h02);
    check("after_drop_tx", last3, 24'h5A0055);

    // Reset while the status byte is still being transmitted
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    t = 0;
    while (!(exp_q.size() == 1 && tx_busy) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("reset_point_bound", t < 2000, 1);
    #1 rst = 1'b1;
    exp_q.delete();
    m_br = 128; m_idx = 0; br_hold = 1; exec_ph = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    t = wr_count;
    repeat (40) @(posedge clk);
    #1;
    check("no_wrsig_after_reset", wr_count, t);
    check("reset_brightness", brightness, 8'h80);
    wait_idle();
    send_frame(8'h02, 8'h00, 8'h02);
    check("post_reset_tx", last3, 24'h5A0080);

    // Partial frame followed by a long silence
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    repeat (1700) @(posedge clk);
    #1;
`ifdef BRIGHT_TIMEOUT_EN
    m_idx = 0;
    m_ferr++;
`endif
    check("timeout_frame_err", n_ferr, m_ferr);
    send_frame(8'h02, 8'h00, 8'h02);
`ifdef BRIGHT_TIMEOUT_EN
    check("timeout_next_tx", last3, 24'h5A0080);
`else
    check("no_timeout_next_tx", last3, 24'h5AEE80);
`endif

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'hA5) c = 8'h00;
        send_byte(c, $urandom_range(0, 3));
      end
      case ($urandom_range(0, 9))
        0, 1, 2: c = 8'h01;
        3:       c = 8'h02;
        4, 5:    c = 8'h03;
        6, 7:    c = 8'h04;
        default: c = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(5, 255));
      endcase
      d = 8'($urandom_range(0, 255));
      k = c ^ d;
      if ($urandom_range(0, 9) == 0) k = k ^ 8'($urandom_range(1, 255));
      send_byte(8'hA5, $urandom_range(0, 4));
      send_byte(c, $urandom_range(0, 4));
      send_byte(d, $urandom_range(0, 4));
      send_byte(k, $urandom_range(0, 4));
      wait_idle();
    end
    check("frame_err_count_end", n_ferr, m_ferr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
